// File: rtl/uart_txr.sv
// UART transmitter: byte FIFO in front of a start/data/stop serialiser.
// Line idles high; frames follow each other with no gap while the FIFO has data.
module uart_txr #(
    parameter int unsigned CLKS_PER_BAUD_PERIOD = 434,
    parameter int unsigned FIFO_DEPTH           = 4,
    parameter bit          MSB_FIRST            = 1'b1,
    parameter int unsigned STOP_BITS            = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_data_valid,
    input  logic [7:0]                    i_data_byte,
    output logic                          o_data_ready,
    output logic                          o_tx_data_line,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned CntW   = (CLKS_PER_BAUD_PERIOD > 2) ? $clog2(CLKS_PER_BAUD_PERIOD) : 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam logic [CntW-1:0]   ClkLast  = CntW'(CLKS_PER_BAUD_PERIOD - 1);
    localparam logic [2:0]        StopLast = 3'(STOP_BITS - 1);
    localparam logic [CountW-1:0] Full     = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q;
    logic [CntW-1:0]   clk_cnt_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        tx_byte_q;
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q, count_d;
    logic              line_q, busy_q, ready_q;

    logic       baud_end, push, pop, next_bit;
    logic [2:0] data_idx;

    always_comb begin
        baud_end = (clk_cnt_q == ClkLast);
        push     = i_data_valid && ready_q;
        // Pop from idle, or at the very end of the last stop bit for back-to-back frames.
        pop      = (count_q != '0) &&
                   ((state_q == StIdle) ||
                    (state_q == StStop && baud_end && bit_cnt_q == StopLast));
        count_d  = count_q + CountW'(push) - CountW'(pop);
        data_idx = (state_q == StStart) ? 3'd0 : bit_cnt_q + 3'd1;
        next_bit = MSB_FIRST ? tx_byte_q[3'd7 - data_idx] : tx_byte_q[data_idx];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_byte_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != Full);
            if (push) begin
                fifo_q[wr_ptr_q] <= i_data_byte;
                wr_ptr_q         <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                tx_byte_q <= fifo_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PtrW'(1);
            end
            clk_cnt_q <= (state_q == StIdle || baud_end) ? '0 : clk_cnt_q + CntW'(1);

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StStart;
                        line_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                        line_q    <= next_bit;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_q   <= StStop;
                            bit_cnt_q <= '0;
                            line_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            line_q    <= next_bit;
                        end
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        if (bit_cnt_q == StopLast) begin
                            bit_cnt_q <= '0;
                            if (pop) begin
                                state_q <= StStart;
                                line_q  <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_data_ready   = ready_q;
    assign o_tx_data_line = line_q;
    assign o_tx_busy      = busy_q;
    assign o_fifo_count   = count_q;

endmodule

// File: doc/uart_txr.md
Name: uart_txr

Overview:
- UART transmitter: the send-side counterpart of the team's UART receiver.
- Accepts bytes through a valid/ready handshake into a small internal FIFO.
- Serialises each byte as start bit (0), 8 data bits, then 1 or 2 stop bits (1), with the line idling high.
- Default bit order is MSB-first, matching the receiver, which stores the first data bit received into bit 7; the two blocks loop back directly.

Parameters:
- CLKS_PER_BAUD_PERIOD, 434: clock cycles per bit period. Minimum 2.
- FIFO_DEPTH, 4: byte FIFO entries. Power of 2, minimum 2.
- MSB_FIRST, 1: 1 = bit 7 sent first; 0 = bit 0 sent first.
- STOP_BITS, 1: number of stop bit periods, 1 or 2.

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_data_valid  input  1  byte on i_data_byte is offered.
- i_data_byte  input  8  byte to transmit.
- o_data_ready  output  1  FIFO can accept a byte (not full); registered.
- o_tx_data_line  output  1  serial output; registered, glitch-free.
- o_tx_busy  output  1  frame in progress (state != IDLE).
- o_fifo_count  output  clog2(FIFO_DEPTH)+1  bytes held in the FIFO, not counting the byte being shifted.

Behaviour:
- Reset (i_rst_n=0 at a posedge) puts the following in effect after that edge:
  - o_tx_data_line=1, o_tx_busy=0, o_data_ready=1, o_fifo_count=0.
  - FIFO pointers cleared, state IDLE, bit and clock counters 0.
- Reset mid-frame aborts the frame at once (line high next cycle) and flushes the FIFO; aborted and queued bytes are lost.
- Push happens when i_data_valid && o_data_ready at a posedge.
  - o_data_ready is computed from the registered count; when full, a push is not accepted even if a pop happens the same cycle.
  - i_data_byte is ignored whenever the push condition is false.
- Pop happens in IDLE when count>0: the head byte is loaded into the shift register and the state goes to START.
  - Push and pop in the same cycle leave the count unchanged; data order is preserved.
- Latency: a byte pushed at edge N into an empty FIFO with state IDLE is popped at edge N+1. o_tx_data_line falls to 0 after edge N+1.
- State machine (states IDLE, START, DATA, STOP):
  - IDLE: line=1, busy=0. Go to START when FIFO non-empty.
  - START: line=0 for exactly CLKS_PER_BAUD_PERIOD cycles, then DATA.
  - DATA: 8 bits, each held exactly CLKS_PER_BAUD_PERIOD cycles, in the order set by MSB_FIRST. After the 8th bit, go to STOP.
  - STOP: line=1 for STOP_BITS*CLKS_PER_BAUD_PERIOD cycles.
    - At the end, if FIFO non-empty: pop and go straight to START (zero idle cycles between frames).
    - Otherwise go to IDLE.
- Frame length is (9+STOP_BITS)*CLKS_PER_BAUD_PERIOD cycles exactly; no cycle is added or dropped at any state boundary.
- The clock counter is wide enough for CLKS_PER_BAUD_PERIOD-1 and counts 0 to CLKS_PER_BAUD_PERIOD-1, then wraps to 0.
- The bit counter counts 0..7.
- FIFO pointers wrap modulo FIFO_DEPTH.
- o_fifo_count=FIFO_DEPTH means full (o_data_ready=0). When a pop occurs, o_data_ready returns to 1 on the next cycle.
- The shift register is loaded only on pop; changes to i_data_byte never affect a frame in progress.

Test Plan:
- Single byte, CLKS_PER_BAUD_PERIOD=16, MSB_FIRST=1, STOP_BITS=1: push 0xA5.
  - Line low 16 cycles starting the cycle after the pop, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles.
  - Busy high for exactly 160 cycles.
- Loopback: connect to the receiver (same CLKS_PER_BAUD_PERIOD); push 0x3C, 0xFF, 0x00.
  - Receiver reports each byte with data_ready asserted.
- Back-to-back and full: push 5 bytes on consecutive cycles with FIFO_DEPTH=4.
  - First byte pops at once; the next 4 fill the FIFO, o_fifo_count=4, o_data_ready=0.
  - A 6th valid is not accepted.
  - Frames are contiguous: stop bit end to next start bit with 0 idle cycles; 5 frames in 800 cycles.
- MSB_FIRST=0, STOP_BITS=2: push 0x01.
  - Data bits 1,0,0,0,0,0,0,0; stop high 32 cycles; frame length 176 cycles.
- Reset mid-frame: assert i_rst_n=0 during data bit 3 with 2 bytes queued.
  - Next cycle: line=1, busy=0, count=0, ready=1.
  - No further frame after reset release until a new push.
- Push while full coincident with a pop at frame end: byte not accepted; count goes 4→3; o_data_ready=1 next cycle.
